// File: rtl/compute_unit_arbiter_pkg.sv
// Shared types and constants for the compute-unit arbiter slice.
package compute_unit_arbiter_pkg;

  localparam int unsigned CU_MAX_REQ = 4;
  localparam int unsigned DATA_DEPTH = 4;
  localparam int unsigned LANE_W     = 16;

  typedef enum logic [1:0] {
    COMP_ADD  = 2'd0,
    COMP_MUL  = 2'd1,
    COMP_RELU = 2'd2,
    COMP_MAX  = 2'd3
  } comp_type_e;

  typedef logic [DATA_DEPTH-1:0][LANE_W-1:0] data_t;

  // Job payload held towards the shared unit for the whole transaction
  typedef struct packed {
    comp_type_e comp_type;
    data_t      data;
  } cu_job_t;

  // Arbiter FSM encoding
  localparam int unsigned ARB_STATE_W = 2;
  localparam logic [ARB_STATE_W-1:0] ARB_IDLE   = 2'd0;
  localparam logic [ARB_STATE_W-1:0] ARB_ISSUE  = 2'd1;
  localparam logic [ARB_STATE_W-1:0] ARB_WAIT   = 2'd2;
  localparam logic [ARB_STATE_W-1:0] ARB_RETURN = 2'd3;

endpackage

// File: rtl/compute_unit_arbiter_if.sv
// Requester and shared-unit bus of the compute-unit arbiter.
// slave = arbiter side, master = requesters plus shared unit.
interface compute_unit_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import compute_unit_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req_valid;
  comp_type_e         req_comp_type [NUM_REQ];
  data_t              req_data      [NUM_REQ];
  logic [NUM_REQ-1:0] req_ack;
  logic [NUM_REQ-1:0] rsp_valid;
  data_t              rsp_data;
  logic               rsp_error;
  logic               busy;
  logic [1:0]         cu_unit_id;
  logic               cu_request;
  comp_type_e         cu_comp_type;
  data_t              cu_data_in;
  logic               cu_ready;
  logic               cu_done;
  data_t              cu_result;

  modport slave (
    input  req_valid, req_comp_type, req_data, cu_ready, cu_done, cu_result,
    output req_ack, rsp_valid, rsp_data, rsp_error, busy,
           cu_unit_id, cu_request, cu_comp_type, cu_data_in
  );

  modport master (
    output req_valid, req_comp_type, req_data, cu_ready, cu_done, cu_result,
    input  req_ack, rsp_valid, rsp_data, rsp_error, busy,
           cu_unit_id, cu_request, cu_comp_type, cu_data_in
  );

endinterface

// File: rtl/compute_unit_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module compute_unit_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         rr_ptr,
  output logic [1:0]         winner_c,
  output logic               any_c
);

  logic [2:0]         idx;
  logic [NUM_REQ-1:0] rot;

  // Scan candidates in priority order starting from rr_ptr
  always_comb begin
    winner_c = 2'd0;
    any_c    = 1'b0;
    idx      = 3'd0;
    rot      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 3'(rr_ptr) + 3'(i);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      rot = req_valid >> idx;
      if (!any_c && rot[0]) begin
        any_c    = 1'b1;
        winner_c = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/compute_unit_arbiter.sv
// compute_unit_arbiter: round-robin sequencer sharing one compute unit among NUM_REQ
// requesters, one job in flight. Define CU_ARB_TIMEOUT_EN to add a watchdog in ARB_WAIT
// that aborts a job after TIMEOUT_CYCLES with rsp_error=1.
module compute_unit_arbiter
  import compute_unit_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  compute_unit_arbiter_if.slave bus
);

  if (NUM_REQ == 0 || NUM_REQ > CU_MAX_REQ || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $fatal(1, "compute_unit_arbiter: NUM_REQ must be 1..4 and TIMEOUT_CYCLES nonzero");
  end

  logic [ARB_STATE_W-1:0] state_q, state_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [1:0]             unit_id_q, unit_id_d;
  cu_job_t                job_q, job_d;
  logic                   cu_request_q, cu_request_d;
  logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  data_t                  rsp_data_q, rsp_data_d;
  logic                   rsp_error_q, rsp_error_d;
  logic                   busy_q, busy_d;
  logic                   busy_seen_q, busy_seen_d;
  logic [1:0]             winner_c;
  logic                   any_c;
  logic                   complete_c;

`ifdef CU_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = 16;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

  compute_unit_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner_c  (winner_c),
    .any_c     (any_c)
  );

  // The unit must have gone busy since the request before ready/done count as completion
  assign complete_c = busy_seen_q && bus.cu_ready && bus.cu_done;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    unit_id_d    = unit_id_q;
    job_d        = job_q;
    cu_request_d = 1'b0;
    req_ack_d    = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;
    busy_seen_d  = busy_seen_q;
`ifdef CU_ARB_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any_c && bus.cu_ready) begin
          unit_id_d       = winner_c;
          job_d.comp_type = bus.req_comp_type[winner_c];
          job_d.data      = bus.req_data[winner_c];
          req_ack_d       = NUM_REQ'(1) << winner_c;
          state_d         = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cu_request_d = 1'b1;
        busy_seen_d  = 1'b0;
`ifdef CU_ARB_TIMEOUT_EN
        wd_cnt_d     = '0;
`endif
        state_d      = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (!bus.cu_ready) busy_seen_d = 1'b1;
        if (complete_c) begin
          rsp_data_d  = bus.cu_result;
          rsp_error_d = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << unit_id_q;
          state_d     = ARB_RETURN;
        end
`ifdef CU_ARB_TIMEOUT_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << unit_id_q;
          state_d     = ARB_RETURN;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      ARB_RETURN: begin
        rr_ptr_d = (unit_id_q == 2'(NUM_REQ - 1)) ? 2'd0 : unit_id_q + 2'd1;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= 2'd0;
      unit_id_q    <= 2'd0;
      job_q        <= '{comp_type: COMP_ADD, data: '0};
      cu_request_q <= 1'b0;
      req_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      busy_q       <= 1'b0;
      busy_seen_q  <= 1'b0;
`ifdef CU_ARB_TIMEOUT_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      unit_id_q    <= unit_id_d;
      job_q        <= job_d;
      cu_request_q <= cu_request_d;
      req_ack_q    <= req_ack_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      busy_q       <= busy_d;
      busy_seen_q  <= busy_seen_d;
`ifdef CU_ARB_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  assign bus.req_ack      = req_ack_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.busy         = busy_q;
  assign bus.cu_unit_id   = unit_id_q;
  assign bus.cu_request   = cu_request_q;
  assign bus.cu_comp_type = job_q.comp_type;
  assign bus.cu_data_in   = job_q.data;

endmodule
